// File: rtl/ldl_pkt_mux_if.sv
// ldl_pkt_mux bundle: per-source beats, arbiter grant and output stream.
// master is the mux side, slave is the surrounding fabric.
interface ldl_pkt_mux_if #(
   parameter int BIN_WIDTH  = 3,
   parameter int REQ_WIDTH  = 1 << BIN_WIDTH,
   parameter int DATA_WIDTH = 32
);
   logic [REQ_WIDTH-1:0]                 s_valid;
   logic [REQ_WIDTH-1:0][DATA_WIDTH-1:0] s_data;
   logic [REQ_WIDTH-1:0]                 s_last;
   logic [REQ_WIDTH-1:0]                 s_ready;
   logic [REQ_WIDTH-1:0]                 arb_req;
   logic [BIN_WIDTH-1:0]                 arb_bin;
   logic                                 arb_valid;
   logic                                 arb_ready;
   logic                                 m_valid;
   logic [DATA_WIDTH-1:0]                m_data;
   logic                                 m_last;
   logic [BIN_WIDTH-1:0]                 m_bin;
   logic                                 m_ready;

   modport master (
      input  s_valid, s_data, s_last,
      input  arb_bin, arb_valid, m_ready,
      output s_ready, arb_req, arb_ready,
      output m_valid, m_data, m_last, m_bin
   );

   modport slave (
      output s_valid, s_data, s_last,
      output arb_bin, arb_valid, m_ready,
      input  s_ready, arb_req, arb_ready,
      input  m_valid, m_data, m_last, m_bin
   );
endinterface

// File: rtl/ldl_pkt_mux.sv
// Packet-locked stream mux behind a round-robin arbiter.
// One grant per packet; one registered output slot.
module ldl_pkt_mux #(
   parameter int BIN_WIDTH  = 3,
   parameter int REQ_WIDTH  = 1 << BIN_WIDTH,
   parameter int DATA_WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   ldl_pkt_mux_if.master bus
);
   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [BIN_WIDTH-1:0]  sel;
   logic                  m_valid_q;
   logic [DATA_WIDTH-1:0] m_data_q;
   logic                  m_last_q;
   logic [BIN_WIDTH-1:0]  m_bin_q;
   logic                  slot_free;
   logic                  accept;

   assign slot_free = !m_valid_q || bus.m_ready;
   assign accept    = (state == XFER) && bus.s_valid[sel] && slot_free;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (bus.arb_valid) state_nxt = XFER;
         XFER: if (accept && bus.s_last[sel]) state_nxt = IDLE;
      endcase
   end

   // Handshake outputs are forced low while reset is held.
   always_comb begin
      bus.arb_req   = '0;
      bus.arb_ready = 1'b0;
      bus.s_ready   = '0;
      if (rst_n) begin
         unique case (state)
            IDLE: begin
               bus.arb_req   = bus.s_valid;
               bus.arb_ready = 1'b1;
            end
            XFER: bus.s_ready[sel] = slot_free;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel       <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
         m_bin_q   <= '0;
      end else begin
         if (state == IDLE && bus.arb_valid) begin
            sel <= bus.arb_bin;
         end
         if (accept) begin
            m_valid_q <= 1'b1;
            m_data_q  <= bus.s_data[sel];
            m_last_q  <= bus.s_last[sel];
            m_bin_q   <= sel;
         end else if (bus.m_ready) begin
            m_valid_q <= 1'b0;
         end
      end
   end

   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = m_data_q;
   assign bus.m_last  = m_last_q;
   assign bus.m_bin   = m_bin_q;
endmodule

// File: tb/tb_ldl_pkt_mux.sv
// Bench for ldl_pkt_mux: directed scenarios plus random traffic
// against a packet-level scoreboard.
module tb_ldl_pkt_mux;
   localparam int BW  = 3;
   localparam int RW  = 8;
   localparam int DW  = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ldl_pkt_mux_if #(.BIN_WIDTH(BW), .REQ_WIDTH(RW), .DATA_WIDTH(DW)) bus ();

   ldl_pkt_mux #(.BIN_WIDTH(BW), .REQ_WIDTH(RW), .DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   // Source packets: {last, data}; pos is the next beat to send.
   logic [32:0] pkt [RW][$];
   int          pos [RW];
   // Expected output stream: {bin, last, data}.
   logic [35:0] exp_q [$];

   logic [RW-1:0] src_en = '0;
   logic          mr = 1'b1;
   logic          av = 1'b0;
   logic [BW-1:0] ab = '0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic new_pkt(input int i, input int len);
      pkt[i].delete();
      for (int b = 0; b < len; b++)
         pkt[i].push_back({b == len - 1, 32'($urandom)});
      pos[i] = 0;
   endtask

   task automatic set_pkt(input int i, input logic [31:0] base,
                          input int len);
      pkt[i].delete();
      for (int b = 0; b < len; b++)
         pkt[i].push_back({b == len - 1, base + 32'(b)});
      pos[i] = 0;
   endtask

   task automatic flush_model();
      exp_q.delete();
      for (int i = 0; i < RW; i++) new_pkt(i, $urandom_range(1, 4));
   endtask

   // A grant commits the whole remaining packet of that source.
   task automatic grant_push(input int b);
      for (int k = pos[b]; k < pkt[b].size(); k++)
         exp_q.push_back({3'(b), pkt[b][k]});
   endtask

   task automatic cycle();
      @(negedge clk);
      for (int i = 0; i < RW; i++) begin
         bus.s_valid[i] = src_en[i];
         bus.s_data[i]  = pkt[i][pos[i]][31:0];
         bus.s_last[i]  = pkt[i][pos[i]][32];
      end
      bus.m_ready   = mr;
      bus.arb_valid = av;
      bus.arb_bin   = ab;
      #1;
      if (bus.arb_valid && bus.arb_ready) grant_push(int'(bus.arb_bin));
      for (int i = 0; i < RW; i++) begin
         if (bus.s_valid[i] && bus.s_ready[i]) begin
            pos[i]++;
            if (pos[i] >= pkt[i].size()) new_pkt(i, $urandom_range(1, 4));
         end
      end
   endtask

   task automatic idle(input int n);
      av = 1'b0;
      mr = 1'b1;
      for (int k = 0; k < n; k++) cycle();
   endtask

   // Monitor: pops the scoreboard on every output handshake.
   logic          hold = 1'b0;
   logic [36:0]   held;
   initial begin
      logic [35:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            hold = 1'b0;
         end else begin
            if (hold)
               chk("hold", {27'b0, bus.m_valid, bus.m_bin, bus.m_last,
                   bus.m_data}, {27'b0, held});
            if (bus.m_valid && bus.m_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_beat", {28'b0, bus.m_bin, bus.m_last,
                      bus.m_data}, 64'hx);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat", {28'b0, bus.m_bin, bus.m_last, bus.m_data},
                      {28'b0, e});
               end
            end
            hold = bus.m_valid && !bus.m_ready;
            held = {bus.m_valid, bus.m_bin, bus.m_last, bus.m_data};
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [5:0]  mv6, ml6, ar6;
      logic [8:0]  mv9;
      logic        bad;
      int          start, idx, n;

      bus.s_valid = '0;
      bus.s_data  = '0;
      bus.s_last  = '0;
      bus.m_ready = 1'b0;
      bus.arb_valid = 1'b0;
      bus.arb_bin = '0;
      flush_model();

      // Reset held with random inputs: every output reads 0.
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         bus.s_valid   = RW'($urandom);
         bus.s_last    = RW'($urandom);
         bus.s_data    = {RW{32'($urandom)}};
         bus.m_ready   = 1'($urandom);
         bus.arb_valid = 1'b1;
         bus.arb_bin   = BW'($urandom);
         #1;
         chk("rst_m_out", {27'b0, bus.m_valid, bus.m_bin, bus.m_last,
             bus.m_data}, 64'd0);
         chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
         chk("rst_arb_req", 64'(bus.arb_req), 64'd0);
         chk("rst_arb_ready", 64'(bus.arb_ready), 64'd0);
      end
      @(negedge clk);
      bus.arb_valid = 1'b0;
      bus.s_valid   = 8'hA5;
      rst_n = 1'b1;
      #1;
      chk("rel_arb_ready", 64'(bus.arb_ready), 64'd1);
      chk("rel_arb_req", 64'(bus.arb_req), 64'(bus.s_valid));
      idle(2);

      // Source 5, four beats, grant in cycle 0.
      set_pkt(5, 32'h10, 4);
      src_en = 8'h20;
      mr = 1'b1;
      ab = 3'd5;
      for (int k = 0; k < 6; k++) begin
         av = (k == 0);
         cycle();
         mv6 = {mv6[4:0], bus.m_valid};
         ml6 = {ml6[4:0], bus.m_last & bus.m_valid};
         ar6 = {ar6[4:0], bus.arb_ready};
      end
      chk("single_m_valid", 64'(mv6), 64'(6'b001111));
      chk("single_m_last", 64'(ml6), 64'(6'b000001));
      chk("single_arb_ready", 64'(ar6), 64'(6'b100001));
      src_en = '0;
      idle(3);

      // Sources 1 and 3 contend; grants 1 then 3.
      set_pkt(1, 32'h100, 3);
      set_pkt(3, 32'h300, 3);
      src_en = 8'h0A;
      bad = 1'b0;
      for (int k = 0; k < 9; k++) begin
         av = (k <= 4);
         ab = (k == 0) ? 3'd1 : 3'd3;
         cycle();
         mv9 = {mv9[7:0], bus.m_valid};
         if (k <= 4) bad |= bus.s_ready[3];
      end
      chk("two_src_bubble", 64'(mv9), 64'(9'b001110111));
      chk("two_src_ready3", 64'(bad), 64'd0);
      src_en = '0;
      idle(3);

      // Backpressure for five cycles mid-packet.
      set_pkt(2, 32'h200, 6);
      src_en = 8'h04;
      ab = 3'd2;
      bad = 1'b0;
      for (int k = 0; k < 15; k++) begin
         av = (k == 0);
         mr = !(k >= 3 && k <= 7);
         cycle();
         if (k >= 3 && k <= 7) bad |= bus.s_ready[2] | !bus.m_valid;
      end
      chk("bp_ready_low", 64'(bad), 64'd0);
      src_en = '0;
      idle(3);

      // Source stalls three cycles mid-packet.
      set_pkt(4, 32'h400, 5);
      ab = 3'd4;
      bad = 1'b0;
      for (int k = 0; k < 12; k++) begin
         av = (k == 0);
         src_en = (k >= 2 && k <= 4) ? 8'h00 : 8'h10;
         cycle();
         if (k >= 2 && k <= 5) bad |= bus.arb_ready;
      end
      chk("stall_xfer", 64'(bad), 64'd0);
      src_en = '0;
      idle(3);

      // Reset while beat 2 of 4 is in flight.
      set_pkt(6, 32'h600, 4);
      src_en = 8'h40;
      ab = 3'd6;
      for (int k = 0; k < 4; k++) begin
         av = (k == 0);
         cycle();
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_m_out", {27'b0, bus.m_valid, bus.m_bin, bus.m_last,
          bus.m_data}, 64'd0);
      chk("mid_rst_s_ready", 64'(bus.s_ready), 64'd0);
      av = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
      flush_model();
      src_en = '0;
      cycle();
      chk("mid_rel_arb_ready", 64'(bus.arb_ready), 64'd1);
      set_pkt(0, 32'h700, 3);
      src_en = 8'h01;
      ab = 3'd0;
      for (int k = 0; k < 7; k++) begin
         av = (k == 0);
         cycle();
      end
      src_en = '0;
      idle(3);

      // Random traffic.
      for (int k = 0; k < 3000; k++) begin
         src_en = RW'($urandom);
         mr = ($urandom_range(0, 3) != 0);
         av = ($urandom_range(0, 2) == 0);
         start = $urandom_range(0, RW - 1);
         idx = start;
         if ($urandom_range(0, 7) != 0) begin
            for (int j = 0; j < RW; j++) begin
               if (src_en[(start + j) % RW]) begin
                  idx = (start + j) % RW;
                  break;
               end
            end
         end
         ab = BW'(idx);
         cycle();
      end

      // Drain: finish any open packet, no new grants.
      av = 1'b0;
      mr = 1'b1;
      src_en = '1;
      n = 0;
      while ((exp_q.size() != 0 || bus.m_valid) && n < 300) begin
         cycle();
         n++;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ldl_pkt_mux.md
# ldl_pkt_mux

Packet-level stream multiplexer that sits directly downstream of the priority round-robin arbiter (`LDL_round_pri`). It exposes per-source arbitration requests, accepts one grant (`arb_bin`/`arb_valid`) per packet, and locks onto the granted source until that packet's last beat is accepted. The selected source's beats pass through a single registered valid/ready output stage. The arbiter only advances its round-robin pointer on packet boundaries, so multi-beat packets are never interleaved.

## Interface
- `BIN_WIDTH`, default 3: width of the source index.
- `REQ_WIDTH`, default `1 << BIN_WIDTH`: number of sources.
- `DATA_WIDTH`, default 32: payload width per beat.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous reset, active-low (0 is reset).
- `s_valid`  in  REQ_WIDTH  per-source beat valid.
- `s_data`  in  REQ_WIDTH x DATA_WIDTH  per-source beat payload (packed array).
- `s_last`  in  REQ_WIDTH  per-source end-of-packet flag.
- `s_ready`  out  REQ_WIDTH  per-source beat accept.
- `arb_req`  out  REQ_WIDTH  request vector to the arbiter's `req`.
- `arb_bin`  in  BIN_WIDTH  granted source index from the arbiter.
- `arb_valid`  in  1  grant valid from the arbiter.
- `arb_ready`  out  1  grant accept; the arbiter advances its pointer on `arb_valid && arb_ready`.
- `m_valid`  out  1  output beat valid.
- `m_data`  out  DATA_WIDTH  output payload.
- `m_last`  out  1  output end-of-packet.
- `m_bin`  out  BIN_WIDTH  source index of the output beat.
- `m_ready`  in  1  downstream accept.

## Operation
- Two states: `IDLE` and `XFER`. A `sel` register holds the locked source index.
- **IDLE**
  - `arb_req = s_valid`, `arb_ready = 1`, `s_ready = 0`.
  - On `arb_valid`: `sel <= arb_bin`, next state is `XFER`.
- **XFER**
  - `arb_req = 0`, `arb_ready = 0`.
  - `s_ready[sel] = !m_valid || m_ready`. All other `s_ready` bits are 0.
  - A beat is accepted when `s_valid[sel] && s_ready[sel]`. On acceptance, `m_data`, `m_last` and `m_bin` load `s_data[sel]`, `s_last[sel]` and `sel`, and `m_valid <= 1`.
  - Acceptance of a beat with `s_last[sel] = 1` sends the state to `IDLE`.
- **Output register**
  - If `m_valid && m_ready` and no new beat is accepted in the same cycle, `m_valid <= 0`.
  - Pop and push in the same cycle is legal and gives 1 beat/cycle throughput.
  - While `m_valid && !m_ready`, `m_data`/`m_last`/`m_bin` hold stable.
- **Source idle mid-packet:** `s_valid[sel]` low in `XFER` leaves the block in `XFER`, waiting indefinitely. No timeout.
- **Non-selected sources** never see `s_ready` during another packet. Their `s_valid` is ignored until the next `IDLE`.
- **Single-beat packet** (`s_last` on the first beat) is legal: `XFER` lasts one accepting cycle.
- **Grant to a source whose `s_valid` drops before XFER** is legal: the block waits in `XFER` for that source.
- **Reset** (async, any time, including mid-packet): state `IDLE`, `sel` 0, `m_valid` 0, `m_data` 0, `m_last` 0, `m_bin` 0. Any partial packet is dropped.

## Timing
- Combinational paths:
  - `arb_ready` and `arb_req` depend only on state and `s_valid`.
  - `s_ready` depends on state, `sel`, `m_valid` and `m_ready`.
  - No combinational path from `arb_valid` or `arb_bin` to any output.
- Latency from a grant captured in cycle N to the first `m_valid`:
  - The first beat can be accepted in N+1.
  - `m_valid` is high in N+2.
- Packet boundary costs exactly one bubble: the last beat is accepted in cycle M, the block is `IDLE` in M+1, and the next first beat is accepted no earlier than M+2.
- Steady-state throughput inside a packet is 1 beat/cycle with `m_ready` held high.

## Test plan
- **Reset values:** hold `rst_n = 0`, drive random inputs. All outputs read 0. Release reset: `arb_ready = 1`, `arb_req == s_valid`.
- **Single source, 4-beat packet** (source 5, data 0x10..0x13, `m_ready = 1`, grant in cycle 0):
  - `m_valid` in cycles 2–5 with data 0x10..0x13 and `m_bin = 5`.
  - `m_last` only in cycle 5.
  - `arb_ready = 0` during cycles 1–4.
  - `IDLE` in cycle 5.
- **Two contending sources** (sources 1 and 3, 3-beat packets each, arbiter grants 1 then 3):
  - Output is 1,1,1,3,3,3 with no interleave.
  - Exactly one bubble cycle between the packets.
  - `s_ready[3]` stays 0 throughout source 1's packet.
- **Backpressure:** hold `m_ready = 0` for 5 cycles mid-packet.
  - `m_*` stay stable and `s_ready[sel] = 0`.
  - After `m_ready` returns high, no beat is lost or duplicated.
- **Source stall:** deassert `s_valid[sel]` for 3 cycles mid-packet.
  - State stays `XFER` and `arb_ready` stays 0.
  - The packet resumes and completes intact.
- **Reset mid-packet:** assert `rst_n = 0` at beat 2 of 4.
  - Outputs go to 0 asynchronously.
  - After release, a new grant for a different source produces a clean packet.
